// File: rtl/lcd_io_ctrl.sv
// lcd_io_ctrl: turns CPU LCD register write requests into timed HD44780 bus cycles.
// Optional macro LCD_INIT_EN adds a power-up delay and a fixed init sequence after reset.
module lcd_io_ctrl #(
  parameter int T_SETUP_CYC = 3,
  parameter int T_EN_CYC    = 25,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000,
  parameter int T_PWRUP_CYC = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_ovf
);

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_T = maxOf(maxOf(maxOf(T_SETUP_CYC, T_EN_CYC), maxOf(T_HOLD_CYC, T_CMD_CYC)),
                               maxOf(T_CLR_CYC, T_PWRUP_CYC));
  localparam int CW = $clog2(MAX_T) + 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
`ifdef LCD_INIT_EN
    , S_PWRUP,
    S_INIT
`endif
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_prev;
  logic            r_on;
  logic            r_en;
  logic            r_rs;
  logic [7:0]      r_data;
  logic            r_busy;
  logic            r_ovf;
  logic            r_pendValid;
  logic            r_pendRs;
  logic [7:0]      r_pendData;

  logic            w_req;
  logic            w_cntZero;
  logic            w_isClr;
  logic            w_waitDone;
  logic            w_initMore;
  logic            w_takePend;
  logic            w_direct;
  logic            w_unused;

  assign w_unused = ^{i_io_lcd[30:11], i_io_lcd[8]};

  assign w_req      = i_io_lcd[10] & ~r_prev;
  assign w_cntZero  = (r_cnt == '0);
  // Clear (0x01) and return-home (0x02/0x03) need the long busy wait
  assign w_isClr    = ~r_rs & (r_data[7:2] == 6'd0) & (r_data != 8'd0);
  assign w_waitDone = (r_state == S_WAIT) & w_cntZero;
  assign w_direct   = (r_state == S_IDLE) & ~r_pendValid;

`ifdef LCD_INIT_EN
  logic [1:0] r_initIdx;
  logic       r_initActive;

  function automatic logic [7:0] initCmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign w_initMore = r_initActive & (r_initIdx != 2'd3);
`else
  assign w_initMore = 1'b0;
`endif

  assign w_takePend = r_pendValid & ((r_state == S_IDLE) | (w_waitDone & ~w_initMore));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
`ifdef LCD_INIT_EN
      r_state      <= S_PWRUP;
      r_cnt        <= CW'(T_PWRUP_CYC - 1);
      r_busy       <= 1'b1;
      r_initIdx    <= 2'd0;
      r_initActive <= 1'b0;
`else
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
`endif
      r_prev       <= 1'b0;
      r_on         <= 1'b0;
      r_en         <= 1'b0;
      r_rs         <= 1'b0;
      r_data       <= 8'd0;
      r_ovf        <= 1'b0;
      r_pendValid  <= 1'b0;
      r_pendRs     <= 1'b0;
      r_pendData   <= 8'd0;
    end else begin
      r_on   <= i_io_lcd[31];
      r_prev <= i_io_lcd[10];

      case (r_state)
        S_IDLE: begin
          if (r_pendValid) begin
            r_rs    <= r_pendRs;
            r_data  <= r_pendData;
            r_cnt   <= LD_SETUP;
            r_state <= S_SETUP;
            r_busy  <= 1'b1;
          end else if (w_req) begin
            r_rs    <= i_io_lcd[9];
            r_data  <= i_io_lcd[7:0];
            r_cnt   <= LD_SETUP;
            r_state <= S_SETUP;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (w_cntZero) begin
            r_cnt   <= LD_EN;
            r_en    <= 1'b1;
            r_state <= S_PULSE;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (w_cntZero) begin
            r_cnt   <= LD_HOLD;
            r_en    <= 1'b0;
            r_state <= S_HOLD;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (w_cntZero) begin
            r_cnt   <= w_isClr ? LD_CLR : LD_CMD;
            r_state <= S_WAIT;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (!w_cntZero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_initMore) begin
`ifdef LCD_INIT_EN
            r_initIdx <= r_initIdx + 2'd1;
            r_state   <= S_INIT;
`endif
          end else begin
`ifdef LCD_INIT_EN
            r_initActive <= 1'b0;
`endif
            // A queued request goes straight back to SETUP without an idle cycle
            if (r_pendValid) begin
              r_rs    <= r_pendRs;
              r_data  <= r_pendData;
              r_cnt   <= LD_SETUP;
              r_state <= S_SETUP;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= w_req;
            end
          end
        end
`ifdef LCD_INIT_EN
        S_PWRUP: begin
          if (w_cntZero) begin
            r_state <= S_INIT;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_INIT: begin
          r_rs         <= 1'b0;
          r_data       <= initCmd(r_initIdx);
          r_cnt        <= LD_SETUP;
          r_initActive <= 1'b1;
          r_state      <= S_SETUP;
        end
`endif
        default: begin
          r_en    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase

      // Consuming the entry frees the slot for a request in the same cycle
      if (w_req && !w_direct) begin
        if (!r_pendValid || w_takePend) begin
          r_pendValid <= 1'b1;
          r_pendRs    <= i_io_lcd[9];
          r_pendData  <= i_io_lcd[7:0];
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (w_takePend) begin
        r_pendValid <= 1'b0;
      end
    end
  end

  assign o_lcd_on   = r_on;
  assign o_lcd_en   = r_en;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = r_data;
  assign o_busy     = r_busy;
  assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_lcd_io_ctrl.sv
// tb_lcd_io_ctrl: directed and randomized bench for lcd_io_ctrl against a
// transaction-timeline reference model (default build, LCD_INIT_EN undefined).
module tb_lcd_io_ctrl;

  localparam int TS   = 2;
  localparam int TE   = 4;
  localparam int TH   = 1;
  localparam int TCMD = 10;
  localparam int TCLR = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ioLcd = 32'd0;
  logic        lcdOn, lcdEn, lcdRs, lcdRw, busy, ovf;
  logic [7:0]  lcdData;

  always #5 clk = ~clk;

  lcd_io_ctrl #(
    .T_SETUP_CYC(TS),
    .T_EN_CYC   (TE),
    .T_HOLD_CYC (TH),
    .T_CMD_CYC  (TCMD),
    .T_CLR_CYC  (TCLR),
    .T_PWRUP_CYC(50)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_io_lcd  (ioLcd),
    .o_lcd_on  (lcdOn),
    .o_lcd_en  (lcdEn),
    .o_lcd_rs  (lcdRs),
    .o_lcd_rw  (lcdRw),
    .o_lcd_data(lcdData),
    .o_busy    (busy),
    .o_ovf     (ovf)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: each transaction is a start edge index plus a total length
  bit         mActive, mPendV, mOvf, mOn, mPrev, mRs, mPendRs;
  logic [7:0] mData, mPendData;
  int         k, mStart, mLen;

  bit prevEnObs;
  int enCount, busyCount, enRises, firstEn, cycIdx;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int txnLen(input bit rs, input logic [7:0] d);
    int waitCyc;
    waitCyc = (!rs && d >= 8'd1 && d <= 8'd3) ? TCLR : TCMD;
    return TS + TE + TH + waitCyc;
  endfunction

  task automatic modelReset();
    mActive = 0; mPendV = 0; mOvf = 0; mOn = 0; mPrev = 0;
    mRs = 0; mPendRs = 0; mData = 8'd0; mPendData = 8'd0;
    k = 0; mStart = 0; mLen = 0;
  endtask

  task automatic startTxn(input bit rs, input logic [7:0] d);
    mActive = 1; mStart = k; mLen = txnLen(rs, d); mRs = rs; mData = d;
  endtask

  task automatic modelStep(input logic [31:0] w);
    bit req;
    k++;
    req   = w[10] && !mPrev;
    mPrev = w[10];
    mOn   = w[31];
    if (mActive && (k - mStart) == mLen) begin
      mActive = 0;
      if (mPendV) begin
        startTxn(mPendRs, mPendData);
        mPendV = 0;
      end
    end else if (!mActive) begin
      if (mPendV) begin
        startTxn(mPendRs, mPendData);
        mPendV = 0;
      end else if (req) begin
        startTxn(w[9], w[7:0]);
        req = 0;
      end
    end
    if (req) begin
      if (!mPendV) begin
        mPendV = 1; mPendRs = w[9]; mPendData = w[7:0];
      end else begin
        mOvf = 1;
      end
    end
  endtask

  task automatic checkAll();
    int  d;
    bit  expEn;
    d     = k - mStart;
    expEn = mActive && d >= TS && d < TS + TE;
    checkOutput("en",   32'(lcdEn),   32'(expEn));
    checkOutput("busy", 32'(busy),    32'(mActive || mPendV));
    checkOutput("rs",   32'(lcdRs),   32'(mRs));
    checkOutput("data", 32'(lcdData), 32'(mData));
    checkOutput("on",   32'(lcdOn),   32'(mOn));
    checkOutput("ovf",  32'(ovf),     32'(mOvf));
    checkOutput("rw",   32'(lcdRw),   32'd0);
    if (lcdEn === 1'b1) enCount++;
    if (busy === 1'b1) busyCount++;
    if (lcdEn === 1'b1 && !prevEnObs) begin
      enRises++;
      if (firstEn < 0) firstEn = cycIdx;
    end
    prevEnObs = (lcdEn === 1'b1);
    cycIdx++;
  endtask

  task automatic clearObs();
    enCount = 0; busyCount = 0; enRises = 0; firstEn = -1; cycIdx = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    ioLcd = w;
    modelStep(w);
    @(negedge clk);
    checkAll();
  endtask

  task automatic holdWord(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) applyStimulus(w);
  endtask

  task automatic asyncReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_en",   32'(lcdEn),   32'd0);
    checkOutput("rst_busy", 32'(busy),    32'd0);
    checkOutput("rst_ovf",  32'(ovf),     32'd0);
    checkOutput("rst_data", 32'(lcdData), 32'd0);
    modelReset();
    prevEnObs = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    modelReset();
    prevEnObs = 0;
    clearObs();
    #1;
    checkOutput("reset_on",   32'(lcdOn),   32'd0);
    checkOutput("reset_en",   32'(lcdEn),   32'd0);
    checkOutput("reset_rs",   32'(lcdRs),   32'd0);
    checkOutput("reset_data", 32'(lcdData), 32'd0);
    checkOutput("reset_busy", 32'(busy),    32'd0);
    checkOutput("reset_ovf",  32'(ovf),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Data write 0x41: EN window and busy length
    clearObs();
    applyStimulus(32'h8000_0641);
    checkOutput("on_latency", 32'(lcdOn), 32'd1);
    holdWord(32'h8000_0641, 29);
    checkOutput("A_en_cycles",   32'(enCount),   32'(TE));
    checkOutput("A_en_start",    32'(firstEn),   32'(TS));
    checkOutput("A_busy_cycles", 32'(busyCount), 32'(TS + TE + TH + TCMD));
    checkOutput("A_rs",   32'(lcdRs),   32'd1);
    checkOutput("A_data", 32'(lcdData), 32'h41);

    // Clear command uses the long wait, function-set uses the short one
    applyStimulus(32'h8000_0000);
    clearObs();
    holdWord(32'h8000_0401, 45);
    checkOutput("B_clr_busy", 32'(busyCount), 32'(TS + TE + TH + TCLR));
    applyStimulus(32'h8000_0000);
    clearObs();
    holdWord(32'h8000_0438, 25);
    checkOutput("B_cmd_busy", 32'(busyCount), 32'(TS + TE + TH + TCMD));

    // Three edges two cycles apart: run, queue, drop
    applyStimulus(32'h8000_0000);
    clearObs();
    applyStimulus(32'h8000_0641);
    applyStimulus(32'h8000_0000);
    applyStimulus(32'h8000_0642);
    applyStimulus(32'h8000_0000);
    applyStimulus(32'h8000_0643);
    holdWord(32'h8000_0000, 60);
    checkOutput("C_en_rises",   32'(enRises),   32'd2);
    checkOutput("C_busy_total", 32'(busyCount), 32'(2 * (TS + TE + TH + TCMD)));
    checkOutput("C_last_data",  32'(lcdData),   32'h42);
    holdWord(32'h8000_0000, 20);
    checkOutput("C_ovf_sticky", 32'(ovf), 32'd1);

    // Reset during the EN pulse
    applyStimulus(32'h8000_0641);
    applyStimulus(32'h8000_0641);
    applyStimulus(32'h8000_0641);
    checkOutput("D_en_before_reset", 32'(lcdEn), 32'd1);
    asyncReset();
    applyStimulus(32'h8000_0000);
    clearObs();
    holdWord(32'h8000_0655, 25);
    checkOutput("D_en_after_reset",   32'(enCount),   32'(TE));
    checkOutput("D_busy_after_reset", 32'(busyCount), 32'(TS + TE + TH + TCMD));

    // Level held high then dropped: exactly one transaction
    applyStimulus(32'h8000_0000);
    clearObs();
    holdWord(32'h8000_0444, 100);
    holdWord(32'h8000_0000, 30);
    checkOutput("E_one_txn", 32'(enRises), 32'd1);

    // Randomized traffic with occasional asynchronous reset
    w = 32'h8000_0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 8 == 0) w[10] = ~w[10];
      if ($urandom % 16 == 0) w[31] = ~w[31];
      w[30:11] = 20'($urandom);
      w[9]     = 1'($urandom);
      w[8]     = 1'($urandom);
      w[7:0]   = ($urandom % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      if ($urandom % 600 == 0) asyncReset();
      applyStimulus(w);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
